// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART defaults and line-state encoding
package uart_pkg;

    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_DATA_BITS  = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } uart_state_e;

endpackage

// File: rtl/uart_sync2.sv
// rtl/uart_sync2.sv - two-flop synchronizer for an idle-high serial line
module uart_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Both stages reset high so an idle line never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling 8N1 UART receiver, optional even parity via UART_RX_PARITY_EN
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int DATA_BITS  = UART_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sample_tick,
    input  logic                 rx,
    input  logic                 data_ready,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic                 parity_err
`endif
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    logic                 line;
    uart_state_e          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 load_q, load_d;
    logic                 ferr_d;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad_q, par_bad_d;
`endif

    uart_sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (line)
    );

    assign busy = (state_q != IDLE);

    // Frame sequencing: everything advances only on sample ticks.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        load_d  = 1'b0;
        ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
`endif
        if (sample_tick) begin
            case (state_q)
                IDLE: begin
                    if (!line) begin
                        state_d = START;
                        cnt_d   = '0;
                    end
                end
                START: begin
                    if (cnt_q == CNT_MID) begin
                        if (line) begin
                            state_d = IDLE;
                        end else begin
                            state_d = DATA;
                            cnt_d   = '0;
                            bit_d   = '0;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        shreg_d = {line, shreg_q[DATA_BITS-1:1]};
                        cnt_d   = '0;
                        bit_d   = bit_q + BIT_W'(1);
                        if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt_q == CNT_LAST) begin
                        par_bad_d = line ^ (^shreg_q);
                        cnt_d     = '0;
                        state_d   = STOP;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
`endif
                STOP: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        if (line) begin
                            load_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = BREAK;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                BREAK: begin
                    if (line) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Receiver state registers; a reset mid-frame simply drops the frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shreg_q   <= '0;
            load_q    <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shreg_q   <= shreg_d;
            load_q    <= load_d;
            frame_err <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= par_bad_d;
`endif
        end
    end

    // Holding register: a new byte always wins; overwriting an unaccepted byte is sticky overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
`ifdef UART_RX_PARITY_EN
            parity_err <= load_q & par_bad_q;
`endif
            if (load_q) begin
                data_out   <= shreg_q;
                data_valid <= 1'b1;
                if (data_valid && !data_ready) begin
                    overrun <= 1'b1;
                end
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver that consumes the line driven by the team's uart_tx: 8N1 frames, LSB first, idle-high.
- Oversamples the line using a single-cycle enable tick at 16x the baud rate, which comes from the baud generator's RX rate.
- Delivers each received byte through a valid/ready holding register.
- Flags framing and overrun errors.

Parameters:
- OVERSAMPLE, 16, sample ticks per bit period; must be an even number of at least 4.
- DATA_BITS, 8, payload bits per frame; allowed range 5..8.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- sample_tick  input  1  one-clk-wide enable pulse at OVERSAMPLE x baud; all line sampling advances only on clk edges where it is high
- rx  input  1  asynchronous serial line, idle high
- data_ready  input  1  consumer accepts data_out when high together with data_valid
- data_out  output  DATA_BITS  last received byte
- data_valid  output  1  data_out holds an unconsumed byte
- frame_err  output  1  single-clk pulse: stop bit sampled low
- overrun  output  1  sticky; a byte completed while data_valid=1 and not being accepted
- busy  output  1  high in every state except IDLE

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE, both synchronizer flops=1, data_out=0, data_valid=0, frame_err=0, overrun=0, busy=0. Reset mid-frame abandons the frame silently.
- rx passes through a 2-flop synchronizer clocked every clk; below, "line" means the synchronizer output.
- Tick counter width is $clog2(OVERSAMPLE); bit index width is $clog2(DATA_BITS).
- State transitions, evaluated on clk edges with sample_tick=1:
  - IDLE: line=0 -> START, counter=0.
  - START: counter increments. At counter=OVERSAMPLE/2-1 (mid start bit), if line=1 it is a glitch -> IDLE. Otherwise -> DATA with counter=0 and bit index=0.
  - DATA: counter increments. At counter=OVERSAMPLE-1, shift the line into the shift register MSB-side (LSB is received first), reset the counter, and increment the bit index. After bit DATA_BITS-1 -> STOP (or PARITY when the optional feature is enabled).
  - STOP: at counter=OVERSAMPLE-1, sample the stop bit.
    - line=1: load the byte and go -> IDLE.
    - line=0: pulse frame_err for 1 clk, do not load, go -> BREAK.
  - BREAK: wait for line=1 on a tick, then -> IDLE. A held-low line therefore produces exactly one frame_err.
- Byte load: data_out<=shift register and data_valid<=1 in the clk after the stop-bit sample. At 16x this is about 9.5 bit times after the start edge.
- Handshake:
  - data_valid && data_ready clears data_valid on the next clk.
  - If a load coincides with acceptance in the same clk, the new byte is loaded and data_valid stays 1, with no overrun.
  - If a load occurs while data_valid=1 and data_ready=0: data_out is overwritten with the new byte and overrun is set.
  - overrun clears only on reset.
- sample_tick=0 freezes the counter, state and sampling. The handshake logic and synchronizer run on every clk.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- When defined: adds a PARITY state between DATA and STOP that samples one even-parity bit at counter=OVERSAMPLE-1.
  - Adds output parity_err (1 bit), a single-clk pulse issued with the load.
  - On mismatch the byte is still loaded and data_valid is asserted.
- When undefined: no PARITY state, no parity_err port, and frames are 8N1 exactly.

Decomposition:
- Shared package uart_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP, BREAK), shared with uart_tx encodings where the names match;
  - the defaults UART_OVERSAMPLE=16 and UART_DATA_BITS=8.
- One sub-module, uart_sync2: the 2-flop synchronizer with a reset value of 1, also reusable for the top-level transmit input.

Test Plan:
- Send 0xA5 at 16 ticks/bit with data_ready held 1 -> data_out=0xA5, data_valid high for 1 clk, frame_err=0, overrun=0.
- 0.3-bit-wide low glitch on rx while idle -> no data_valid, busy returns to 0, state IDLE.
- Frame 0x3C with stop bit forced 0, then rx held low for 3 bit times -> frame_err pulses exactly once, data_valid stays 0, next valid frame 0x55 is received correctly.
- Two back-to-back frames 0x11 then 0x22 with data_ready=0 -> data_out=0x22, data_valid=1, overrun=1. Then data_ready=1 for 1 clk -> data_valid=0 and overrun stays 1.
- Assert rst_n=0 mid-DATA of frame 0xFF, release, send 0x81 -> only 0x81 is delivered, and all outputs were 0 during reset.
- With UART_RX_PARITY_EN: 0x07 with correct even parity bit 1 -> parity_err=0; same byte with parity bit 0 -> parity_err pulses and data_out=0x07.
